// File: rtl/stage_sequencer_if.sv
// Stage sequencer bus: core status/control inputs and per-stage enables.
// Optional single-step input is present only when STAGE_SEQ_SINGLE_STEP_EN
// is defined.
//
// Protocol: there is no valid/ready pair on this bus. Each en_* is a
// one-cycle strobe that the core treats as "perform this stage's work on
// this CLK edge"; the strobes are mutually exclusive. memWait/exBusy act as
// the ready side: while the stage's stall input is high its enable is held
// low and the stage is repeated on the next tick.
interface stage_sequencer_if;
  logic       run;
  logic       halt_req;
  logic       memWait;
  logic       rwmem;
  logic       exBusy;
`ifdef STAGE_SEQ_SINGLE_STEP_EN
  logic       step;
`endif
  logic       en_ft;
  logic       en_dc;
  logic       en_ex;
  logic       en_ma;
  logic       en_wb;
  logic [2:0] stage;
  logic       instret;
  logic       halted;
  logic       mem_timeout;

  // Sequencer side
  modport master (
    input  run, halt_req, memWait, rwmem, exBusy,
`ifdef STAGE_SEQ_SINGLE_STEP_EN
    input  step,
`endif
    output en_ft, en_dc, en_ex, en_ma, en_wb, stage, instret, halted,
           mem_timeout
  );

  // Core / controller side
  modport slave (
    output run, halt_req, memWait, rwmem, exBusy,
`ifdef STAGE_SEQ_SINGLE_STEP_EN
    output step,
`endif
    input  en_ft, en_dc, en_ex, en_ma, en_wb, stage, instret, halted,
           mem_timeout
  );
endinterface

// File: rtl/stage_sequencer.sv
// Single-clock stage sequencer for the multi-cycle RV32 core.
// Walks FT -> DC -> EX -> (MA) -> WB on a divided tick, issuing one-cycle
// stage enables, with memory/execute stalls, run/halt control and a
// memory-stall watchdog.
// Optional feature macro: STAGE_SEQ_SINGLE_STEP_EN (adds the step input).
module stage_sequencer #(
  parameter int STEP_DIV = 1,   // CLK cycles per tick, >= 1
  parameter int TIMEOUT  = 255  // stalled ticks before abort, 0 = off
) (
  input  logic               CLK,
  input  logic               RST_N,
  stage_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FT   = 3'd1,
    S_DC   = 3'd2,
    S_EX   = 3'd3,
    S_MA   = 3'd4,
    S_WB   = 3'd5
  } state_t;

  localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t        state_q, state_d;
  logic [DW-1:0] div_q;
  logic [CW-1:0] cnt_q;
  logic          tick;
  logic          mem_stall;
  logic          wd_fire;
  logic          start_req;
  logic          wb_continue;
  logic          leave_idle;
  logic          timeout_q;

  assign tick      = (div_q == DIV_LAST);
  assign mem_stall = ((state_q == S_FT) || (state_q == S_MA)) && bus.memWait;
  // Fires on the tick that would bring the stall count up to TIMEOUT.
  assign wd_fire   = (TIMEOUT != 0) && tick && mem_stall && (cnt_q == CNT_LAST);

`ifdef STAGE_SEQ_SINGLE_STEP_EN
  logic step_pend_q;
  logic single_q;
  assign start_req   = (bus.run || step_pend_q) && !bus.halt_req;
  assign wb_continue = bus.run && !bus.halt_req && !single_q;
`else
  assign start_req   = bus.run && !bus.halt_req;
  assign wb_continue = start_req;
`endif

  assign leave_idle = tick && (state_q == S_IDLE) && start_req;

  // Stage enables: current stage, on a tick, when not stalled.
  assign bus.en_ft = (state_q == S_FT) && tick && !bus.memWait;
  assign bus.en_dc = (state_q == S_DC) && tick;
  assign bus.en_ex = (state_q == S_EX) && tick && !bus.exBusy;
  assign bus.en_ma = (state_q == S_MA) && tick && !bus.memWait;
  assign bus.en_wb = (state_q == S_WB) && tick;

  assign bus.stage       = state_q;
  assign bus.instret     = bus.en_wb;
  assign bus.halted      = (state_q == S_IDLE);
  assign bus.mem_timeout = timeout_q;

  // Free-running tick divider; never disturbed by stalls or state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + 1'b1;
  end

  // Consecutive memory-stall tick counter for the watchdog.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (tick) begin
      if (wd_fire || !mem_stall || (TIMEOUT == 0)) cnt_q <= '0;
      else                                          cnt_q <= cnt_q + 1'b1;
    end
  end

  // Sticky abort flag; cleared when the sequencer next leaves IDLE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)          timeout_q <= 1'b0;
    else if (wd_fire)    timeout_q <= 1'b1;
    else if (leave_idle) timeout_q <= 1'b0;
  end

`ifdef STAGE_SEQ_SINGLE_STEP_EN
  // Step request capture and one-instruction mode tracking.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      step_pend_q <= 1'b0;
      single_q    <= 1'b0;
    end else if (leave_idle) begin
      step_pend_q <= 1'b0;
      single_q    <= !bus.run;
    end else if ((state_q == S_IDLE) && bus.step && !bus.run) begin
      step_pend_q <= 1'b1;
    end
  end
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; transitions only happen on a tick.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        S_IDLE: if (start_req) state_d = S_FT;
        S_FT: begin
          if (wd_fire)          state_d = S_IDLE;
          else if (bus.en_ft)   state_d = S_DC;
        end
        S_DC:   if (bus.en_dc) state_d = S_EX;
        S_EX:   if (bus.en_ex) state_d = bus.rwmem ? S_MA : S_WB;
        S_MA: begin
          if (wd_fire)          state_d = S_IDLE;
          else if (bus.en_ma)   state_d = S_WB;
        end
        S_WB:   state_d = wb_continue ? S_FT : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Testbench for stage_sequencer: directed vector table, hand-written
// multi-cycle sequences and randomized stimulus against a queue-based model.
module tb_stage_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  stage_sequencer_if ifa();
  stage_sequencer_if ifb();

  stage_sequencer #(.STEP_DIV(1), .TIMEOUT(5)) dut_a (
    .CLK(clk), .RST_N(rst_n), .bus(ifa)
  );

  stage_sequencer #(.STEP_DIV(4), .TIMEOUT(255)) dut_b (
    .CLK(clk), .RST_N(rst_n), .bus(ifb)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [10:0] exp_q[$];

  // ---------------- reference model ----------------
  // The instruction in flight is a queue of stage numbers still to run;
  // an empty queue means IDLE.
  int m_sd, m_to, m_div, m_cnt;
  bit m_tof;
  int m_q[$];

  task automatic model_reset(input int sd, input int to);
    m_sd = sd; m_to = to; m_div = 0; m_cnt = 0; m_tof = 0;
    m_q.delete();
  endtask

  function automatic logic [10:0] model_exp(input logic r, h, m, w, e);
    int cur;
    bit tk, st;
    logic [4:0] en;
    cur = (m_q.size() != 0) ? m_q[0] : 0;
    tk  = (m_div == m_sd - 1);
    st  = (((cur == 1) || (cur == 4)) && m) || ((cur == 3) && e);
    en  = '0;
    if (cur != 0 && tk && !st) en[cur-1] = 1'b1;
    return {3'(cur), en, (cur == 0), en[4], m_tof};
  endfunction

  task automatic model_step(input logic r, h, m, w, e);
    int cur, p;
    bit tk;
    cur = (m_q.size() != 0) ? m_q[0] : 0;
    tk  = (m_div == m_sd - 1);
    if (tk) begin
      if (cur == 0) begin
        m_cnt = 0;
        if (r && !h) begin
          m_q.push_back(1); m_q.push_back(2); m_q.push_back(3);
          m_tof = 0;
        end
      end else if (((cur == 1) || (cur == 4)) && m) begin
        if (m_to != 0 && m_cnt + 1 >= m_to) begin
          m_q.delete(); m_tof = 1; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end else begin
        m_cnt = 0;
        if (!((cur == 3) && e)) begin
          p = m_q.pop_front();
          if (p == 3) begin
            if (w) m_q.push_back(4);
            m_q.push_back(5);
          end
          if (p == 5 && r && !h) begin
            m_q.push_back(1); m_q.push_back(2); m_q.push_back(3);
          end
        end
      end
    end
    m_div = (m_div + 1) % m_sd;
  endtask

  // ---------------- helpers ----------------
  // obs packing: {stage[2:0], en_wb, en_ma, en_ex, en_dc, en_ft, halted, instret, mem_timeout}
  function automatic logic [10:0] obs(input bit sel);
    if (sel == 1'b0)
      return {ifa.stage, ifa.en_wb, ifa.en_ma, ifa.en_ex, ifa.en_dc, ifa.en_ft,
              ifa.halted, ifa.instret, ifa.mem_timeout};
    else
      return {ifb.stage, ifb.en_wb, ifb.en_ma, ifb.en_ex, ifb.en_dc, ifb.en_ft,
              ifb.halted, ifb.instret, ifb.mem_timeout};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input bit sel, input logic r, h, m, w, e);
    if (sel == 1'b0) begin
      ifa.run = r; ifa.halt_req = h; ifa.memWait = m; ifa.rwmem = w; ifa.exBusy = e;
      ifb.run = 0; ifb.halt_req = 0; ifb.memWait = 0; ifb.rwmem = 0; ifb.exBusy = 0;
    end else begin
      ifb.run = r; ifb.halt_req = h; ifb.memWait = m; ifb.rwmem = w; ifb.exBusy = e;
      ifa.run = 0; ifa.halt_req = 0; ifa.memWait = 0; ifa.rwmem = 0; ifa.exBusy = 0;
    end
  endtask

  // Enters and leaves at a negedge; releases reset on a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One model-checked cycle: drive, compare, advance model on the edge.
  task automatic mc(input bit sel, input logic r, h, m, w, e, output logic [10:0] o);
    set_in(sel, r, h, m, w, e);
    #1;
    exp_q.push_back(model_exp(r, h, m, w, e));
    o = obs(sel);
    check($sformatf("model_dut%0d", sel), o, exp_q.pop_front());
    @(posedge clk);
    model_step(r, h, m, w, e);
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       run, halt, mw, rw, eb;
    logic [2:0] stage;
    logic [4:0] en;   // {wb, ma, ex, dc, ft}
    logic       halted;
  } vec_t;

  vec_t tbl[17];

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [10:0] o;
    bit found;
    int ft_cycles, busy_ex, post_ex, first_ex, cyc;
    logic r, h, m, w, e;
    int burst;

    //             run h  mw rw eb stage en     halted
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd0, 5'h00, 1'b1};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd1, 5'h01, 1'b0};
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd2, 5'h02, 1'b0};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 3'd3, 5'h04, 1'b0};
    tbl[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 3'd4, 5'h00, 1'b0};
    tbl[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 3'd4, 5'h00, 1'b0};
    tbl[6]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 3'd4, 5'h00, 1'b0};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd4, 5'h08, 1'b0};
    tbl[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd5, 5'h10, 1'b0};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 3'd1, 5'h01, 1'b0};
    tbl[10] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 3'd2, 5'h02, 1'b0};
    tbl[11] = '{1'b1,1'b1,1'b0,1'b0,1'b1, 3'd3, 5'h00, 1'b0};
    tbl[12] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 3'd3, 5'h04, 1'b0};
    tbl[13] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 3'd5, 5'h10, 1'b0};
    tbl[14] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 3'd0, 5'h00, 1'b1};
    tbl[15] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd0, 5'h00, 1'b1};
    tbl[16] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd1, 5'h01, 1'b0};

    // Reset values on both instances.
    do_reset();
    #1;
    check("reset_a", obs(0), 11'b000_00000_100);
    check("reset_b", obs(1), 11'b000_00000_100);
    @(negedge clk);
    do_reset();

    // Directed table on the STEP_DIV=1 instance.
    for (int i = 0; i < 17; i++) begin
      set_in(0, tbl[i].run, tbl[i].halt, tbl[i].mw, tbl[i].rw, tbl[i].eb);
      #1;
      check($sformatf("vec%0d", i), obs(0),
            {tbl[i].stage, tbl[i].en, tbl[i].halted, tbl[i].en[4], 1'b0});
      @(posedge clk);
      @(negedge clk);
    end

    // Asynchronous reset while in EX.
    do_reset();
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      set_in(0, 1, 0, 0, 0, 1);
      #1;
      if (ifa.stage == 3'd3) found = 1;
      else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    check("mid_ex_reached", 32'(found), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("async_reset_mid_ex", obs(0), 11'b000_00000_100);
    @(negedge clk);
    rst_n = 1'b1;

    // Watchdog: memWait stuck in FT with TIMEOUT=5.
    do_reset();
    model_reset(1, 5);
    ft_cycles = 0;
    o = '0;
    for (int i = 0; i < 20; i++) begin
      mc(0, 1, 0, 1, 0, 0, o);
      if (o[10:8] == 3'd1) ft_cycles++;
      if (o[0]) break;
    end
    check("wd_stalled_ft_ticks", 32'(ft_cycles), 32'd5);
    check("wd_abort_state", o, 11'b000_00000_101);
    mc(0, 1, 0, 0, 0, 0, o);
    check("wd_restart_clears", o, 11'b001_00001_000);

    // exBusy in EX with STEP_DIV=4.
    do_reset();
    model_reset(4, 255);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      mc(1, 1, 0, 0, 0, 1, o);
      if (o[10:8] == 3'd3) found = 1;
    end
    check("b_reached_ex", 32'(found), 32'd1);
    busy_ex = 0;
    for (int i = 0; i < 10; i++) begin
      mc(1, 1, 0, 0, 0, 1, o);
      if (o[5]) busy_ex++;
    end
    check("b_no_ex_while_busy", 32'(busy_ex), 32'd0);
    post_ex = 0;
    first_ex = -1;
    cyc = -1;
    for (int i = 0; i < 8; i++) begin
      mc(1, 1, 0, 0, 0, 0, o);
      if (o[5]) begin
        post_ex++;
        if (first_ex < 0) first_ex = i;
      end
    end
    check("b_single_ex_pulse", 32'(post_ex), 32'd1);
    // Reset released at a negedge: cycle counts from there give divider phase.
    // 2 + 1 + 10 cycles elapsed before this window started, plus the
    // cycles spent reaching EX; only phase 3 may carry a tick.
    check("b_ex_within_one_tick", 32'(first_ex >= 0 && first_ex < 4), 32'd1);

    // Randomized runs on both instances.
    for (int sel = 0; sel < 2; sel++) begin
      do_reset();
      if (sel == 0) model_reset(1, 5);
      else          model_reset(4, 255);
      burst = 0;
      for (int i = 0; i < 1500; i++) begin
        r = ($urandom_range(0, 9) < 8);
        h = ($urandom_range(0, 9) == 0);
        w = 1'($urandom_range(0, 1));
        e = ($urandom_range(0, 9) < 3);
        if (burst > 0) begin
          m = 1'b1;
          burst--;
        end else begin
          if ($urandom_range(0, 59) == 0) burst = $urandom_range(3, 12);
          m = ($urandom_range(0, 9) < 3);
        end
        mc(sel[0], r, h, m, w, e, o);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
